// File: rtl/data_mem_pipe.sv
// data_mem_pipe: pipelined data-memory port with a valid/ready request
// channel, a fixed-latency response channel, bounds/alignment checking and
// a zero-fill sweep after reset.
// Optional feature macro: MEM_BYTE_WE_EN (per-byte write strobes on req_be).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_CLEAR | zero-fill sweep, one word per cycle, requests not accepted
// S_RUN   | normal operation, req_ready=1
module data_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int IDX = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * NB);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [IDX-1:0]  cnt_q, cnt_d;
    logic            clr_we;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc;
    logic              err;
    logic              wr_en;
    logic              rd_en;
    logic [IDX-1:0]    widx;
    logic [DATA_W-1:0] rd_d;

    logic [RD_LAT-1:0] pv_q;
    logic [RD_LAT-1:0] pe_q;
    logic [DATA_W-1:0] pd_q [RD_LAT];

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    assign req_ready = (state_q == S_RUN);
    assign acc       = req_valid && req_ready && !rst;
    assign err       = (|req_addr[OFF-1:0]) || ({1'b0, req_addr} >= LIMIT);
    assign widx      = req_addr[OFF+IDX-1:OFF];
    assign wr_en     = acc && req_we && !err;
    assign rd_en     = acc && !req_we && !err;
    // Read data is captured at acceptance so earlier writes are already visible.
    assign rd_d      = rd_en ? mem_q[widx] : '0;

    // Sweep sequencing: next state and sweep-write enable.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + IDX'(1);
                if (cnt_q == IDX'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            default: ;
        endcase
    end

    // State register and sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage writes: zero fill during the sweep, legal stores during run.
    always_ff @(posedge clk) begin
        if (clr_we && !rst) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
`ifdef MEM_BYTE_WE_EN
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    mem_q[widx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
`else
            mem_q[widx] <= req_wdata;
`endif
        end
    end

`ifndef MEM_BYTE_WE_EN
    logic unused_be;
    assign unused_be = ^req_be;
`endif

    // Response pipeline; payloads are zero unless carrying a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q        <= '0;
            pe_q        <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pd_q[k] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            pv_q[0] <= acc;
            pe_q[0] <= acc && err;
            pd_q[0] <= rd_d;
            for (int k = 1; k < RD_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pe_q[k] <= pe_q[k-1];
                pd_q[k] <= pd_q[k-1];
            end
            rsp_valid_q <= pv_q[RD_LAT-1];
            rsp_rdata_q <= pd_q[RD_LAT-1];
            rsp_err_q   <= pe_q[RD_LAT-1];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Testbench for data_mem_pipe: two instances (RD_LAT=1 and RD_LAT=3,
// DEPTH=16) driven in lockstep and checked every cycle against a
// transaction-level model, plus a directed vector table and corner sequences.
module tb_data_mem_pipe;
    localparam int DEP = 16;
    localparam int LIM = DEP * 4;

`ifdef MEM_BYTE_WE_EN
    localparam logic [31:0] BYTE_EXP = 32'h11BB33DD;
    localparam logic [31:0] BE0_EXP  = 32'h11BB33DD;
`else
    localparam logic [31:0] BYTE_EXP = 32'hAABBCCDD;
    localparam logic [31:0] BE0_EXP  = 32'hFFFFFFFF;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rdy1, rv1, re1, rdy3, rv3, re3;
    logic [31:0] rd1, rd3;

    data_mem_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1));

    data_mem_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .RD_LAT(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3));

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    // model state: word array, sweep progress, per-edge accepted responses
    logic [31:0] m_mem [DEP];
    int          clr_cnt = 0;
    bit          rec_v [4096];
    logic [31:0] rec_d [4096];
    bit          rec_e [4096];

    // observed responses
    logic [31:0] q1[$], q3[$];
    bit          e1[$], e3[$];
    int          c1[$], c3[$];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t vt[15];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_q();
        q1.delete(); q3.delete(); e1.delete(); e3.delete(); c1.delete(); c3.delete();
    endtask

    task automatic check_lat(input int lat, input logic v, input logic [31:0] d, input logic e);
        int  idx;
        bit  ev;
        idx = cyc - lat;
        ev  = (idx >= 1) && rec_v[idx];
        cmp($sformatf("rsp_valid L%0d", lat), {31'b0, v}, {31'b0, ev});
        cmp($sformatf("rsp_rdata L%0d", lat), d, ev ? rec_d[idx] : 32'h0);
        cmp($sformatf("rsp_err L%0d", lat), {31'b0, e}, {31'b0, ev ? rec_e[idx] : 1'b0});
    endtask

    // one clock: update the model with the current inputs, then sample the DUTs
    task automatic step();
        bit          acc, err;
        int          idx;
        logic [31:0] rd;
        cyc++;
        if (rst) begin
            for (int k = 0; k <= 4; k++) if (cyc - k >= 0) rec_v[cyc-k] = 1'b0;
            for (int k = 0; k < DEP; k++) m_mem[k] = 32'h0;
            clr_cnt = 0;
        end else begin
            acc = req_valid && (clr_cnt >= DEP);
            rec_v[cyc] = acc;
            rec_d[cyc] = 32'h0;
            rec_e[cyc] = 1'b0;
            if (acc) begin
                err = (req_addr % 4 != 0) || (req_addr >= LIM);
                idx = int'(req_addr[5:2]);
                rd  = 32'h0;
                if (!err && !req_we) rd = m_mem[idx];
                if (!err && req_we) begin
`ifdef MEM_BYTE_WE_EN
                    for (int b = 0; b < 4; b++)
                        if (req_be[b]) m_mem[idx][b*8 +: 8] = req_wdata[b*8 +: 8];
`else
                    m_mem[idx] = req_wdata;
`endif
                end
                rec_d[cyc] = rd;
                rec_e[cyc] = err;
            end
            if (clr_cnt < DEP) clr_cnt++;
        end
        @(posedge clk);
        #1;
        cmp("req_ready L1", {31'b0, rdy1}, {31'b0, clr_cnt >= DEP});
        cmp("req_ready L3", {31'b0, rdy3}, {31'b0, clr_cnt >= DEP});
        check_lat(1, rv1, rd1, re1);
        check_lat(3, rv3, rd3, re3);
        if (rv1 === 1'b1) begin q1.push_back(rd1); e1.push_back(re1); c1.push_back(cyc); end
        if (rv3 === 1'b1) begin q3.push_back(rd3); e3.push_back(re3); c3.push_back(cyc); end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h04, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 32'h04, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 32'h04, 32'h0,        4'h0, BYTE_EXP,     1'b0};
        vt[5]  = '{1'b0, 32'h02, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[6]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vt[7]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0};
        vt[8]  = '{1'b1, 32'h01, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vt[9]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0};
        vt[10] = '{1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vt[11] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vt[12] = '{1'b0, 32'h3F, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[13] = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vt[14] = '{1'b0, 32'h04, 32'h0,        4'h0, BE0_EXP,      1'b0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        for (int k = 0; k < DEP; k++) m_mem[k] = 32'h0;

        // reset for 3 cycles, then the sweep; requests held during it are ignored
        idle(3);
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h55555555; req_be = 4'hF;
        for (int i = 0; i < DEP - 1; i++) step();
        cmp("ready before sweep end", {31'b0, rdy1}, 32'h0);
        req_valid = 1'b0;
        step();
        cmp("ready after sweep", {31'b0, rdy3}, 32'h1);

        // reset in the middle of the sweep restarts it from word 0
        rst = 1'b1; step(); rst = 1'b0;
        idle(8);
        rst = 1'b1; step(); rst = 1'b0;
        idle(DEP);

        // directed vector table, one request at a time
        for (int i = 0; i < 15; i++) begin
            clear_q();
            issue(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be);
            idle(4);
            cmp($sformatf("tbl%0d count L1", i), 32'(q1.size()), 32'd1);
            cmp($sformatf("tbl%0d count L3", i), 32'(q3.size()), 32'd1);
            if (q1.size() == 1 && q3.size() == 1) begin
                cmp($sformatf("tbl%0d rdata L1", i), q1[0], vt[i].exp_rd);
                cmp($sformatf("tbl%0d rdata L3", i), q3[0], vt[i].exp_rd);
                cmp($sformatf("tbl%0d err L1", i), {31'b0, e1[0]}, {31'b0, vt[i].exp_err});
                cmp($sformatf("tbl%0d err L3", i), {31'b0, e3[0]}, {31'b0, vt[i].exp_err});
            end
        end

        // write then read the same word on the next cycle
        clear_q();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BADF00D; req_be = 4'hF;
        step();
        req_we = 1'b0;
        step();
        idle(4);
        cmp("b2b count L3", 32'(q3.size()), 32'd2);
        if (q3.size() == 2) begin
            cmp("b2b wr rsp L3", q3[0], 32'h0);
            cmp("b2b rd rsp L3", q3[1], 32'h0BADF00D);
            cmp("b2b spacing L3", 32'(c3[1] - c3[0]), 32'd1);
        end

        // 8 preloaded words read back to back
        for (int i = 0; i < 8; i++) issue(1'b1, 32'(i * 4), 32'hA5000000 + 32'(i * 32'h111), 4'hF);
        idle(4);
        clear_q();
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 32'(i * 4);
            step();
        end
        idle(4);
        cmp("thru count L1", 32'(q1.size()), 32'd8);
        cmp("thru count L3", 32'(q3.size()), 32'd8);
        if (q3.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                cmp($sformatf("thru data%0d L3", i), q3[i], 32'hA5000000 + 32'(i * 32'h111));
                cmp($sformatf("thru cycle%0d L3", i), 32'(c3[i] - c3[0]), 32'(i));
            end
        end

        // reset while two reads are in flight
        clear_q();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h08;
        step();
        req_addr = 32'h0C;
        step();
        req_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        idle(DEP);
        idle(4);
        cmp("midflight count L3", 32'(q3.size()), 32'd0);
        cmp("midflight count L1", 32'(q1.size()), 32'd1);
        clear_q();
        issue(1'b0, 32'h08, 32'h0, 4'h0);
        idle(4);
        cmp("post-sweep count L3", 32'(q3.size()), 32'd1);
        if (q3.size() == 1) cmp("post-sweep rdata L3", q3[0], 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 9);
            if (r < 7)       req_addr = 32'($urandom_range(0, DEP - 1) * 4);
            else if (r == 7) req_addr = 32'($urandom_range(0, 127));
            else             req_addr = $urandom;
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0;
        idle(DEP + 6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
